// File: rtl/mips_mem_dump.sv
// mips_mem_dump
//   Read-out engine for the single-cycle MIPS core's data memory. An accepted
//   start halts the core. The engine then reads a contiguous range of words
//   through the memory's combinational read port. Each word is streamed out
//   on a valid/ready interface together with its address.
//
// Ports
//   clk        clock; every state update happens on the rising edge
//   rst        asynchronous, active-low reset
//   start      one-cycle dump request; only looked at while idle
//   base_addr  first word address; latched when start is accepted
//   count      number of words, 0 .. 2**ADDR_W; latched when start is accepted
//   abort      cancels a dump that is in progress
//   halt_cpu   stalls the core's PC, register file and memory writes
//   mem_addr   data-memory read address
//   mem_rd_en  read strobe; high only while a word is being read
//   mem_rdata  combinational read data for mem_addr
//   out_valid  a dumped word is on out_data / out_addr
//   out_ready  the sink accepts the word
//   out_data   the dumped word
//   out_addr   the word address of out_data
//   busy       high whenever a dump is in progress
//   done       one-cycle pulse when a dump completes
module mips_mem_dump #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int HALT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  output logic              halt_cpu,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam int HC_W = (HALT_CYCLES < 1) ? 1 : $clog2(HALT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, HALT, READ, SEND, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;   // one bit wider so a full-memory dump fits
  logic [HC_W-1:0]   halt_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      halt_cnt  <= '0;
      halt_cpu  <= 1'b0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort wins over everything, including a handshake in the same cycle.
      if (state != IDLE && abort) begin
        state     <= IDLE;
        halt_cpu  <= 1'b0;
        mem_rd_en <= 1'b0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (count == '0) begin
                // An empty dump completes at once, without disturbing the core.
                done <= 1'b1;
              end else begin
                cur_addr  <= base_addr;
                remaining <= count;
                halt_cnt  <= '0;
                halt_cpu  <= 1'b1;
                busy      <= 1'b1;
                state     <= HALT;
              end
            end
          end
          HALT: begin
            // halt_cpu is already registered high on entry. The extra count
            // step gives the core HALT_CYCLES full cycles of seeing the
            // stall before the first read.
            if (halt_cnt == HC_W'(HALT_CYCLES)) begin
              mem_addr  <= cur_addr;
              mem_rd_en <= 1'b1;
              state     <= READ;
            end else begin
              halt_cnt <= halt_cnt + HC_W'(1);
            end
          end
          READ: begin
            out_data  <= mem_rdata;
            out_addr  <= mem_addr;
            out_valid <= 1'b1;
            mem_rd_en <= 1'b0;
            state     <= SEND;
          end
          SEND: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (remaining == (ADDR_W+1)'(1)) begin
                done     <= 1'b1;
                halt_cpu <= 1'b0;
                busy     <= 1'b0;
                state    <= DONE;
              end else begin
                // The address wraps naturally at the top of memory.
                cur_addr  <= cur_addr + ADDR_W'(1);
                mem_addr  <= cur_addr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
                mem_rd_en <= 1'b1;
                state     <= READ;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_dump.sv
module tb_mips_mem_dump;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  count;
  logic        abort;
  logic        halt_cpu;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_addr;
  logic        busy;
  logic        done;

  int tests  = 0;
  int failed = 0;

  logic [31:0] mem [256];

  mips_mem_dump #(.ADDR_W(8), .DATA_W(32), .HALT_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .abort     (abort),
    .halt_cpu  (halt_cpu),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_word(input logic [7:0] a);
    case (a)
      8'h00:   return 32'h11111111;
      8'h01:   return 32'h22222222;
      8'h02:   return 32'h33333333;
      8'h03:   return 32'h44444444;
      default: return 32'hC0DE0000 | {24'h0, a};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic kick(input logic [7:0] b, input logic [8:0] c);
    start     = 1'b1;
    base_addr = b;
    count     = c;
    tick();
    start = 1'b0;
  endtask

  // Consumes a dump until its done pulse, checking every beat and optionally
  // holding out_ready low for stall_len cycles on beat number stall_beat.
  task automatic drain(input logic [7:0] base, input int n,
                       input int stall_beat, input int stall_len);
    int         beats;
    int         dones;
    int         stall;
    bit         finished;
    logic [7:0] a;
    beats = 0; dones = 0; stall = 0; finished = 0;
    for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
      if (done) begin
        dones++;
        finished = 1;
      end else if (out_valid) begin
        a = base + 8'(beats);
        check("beat_addr", 64'(out_addr), 64'(a));
        check("beat_data", 64'(out_data), 64'(exp_word(a)));
        check("beat_halt", 64'(halt_cpu), 64'(1));
        if (beats == stall_beat && stall < stall_len) begin
          check("stall_rd_en", 64'(mem_rd_en), 64'(0));
          check("stall_mem_addr", 64'(mem_addr), 64'(a));
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
          beats++;
        end
      end
      if (!finished) tick();
    end
    out_ready = 1'b1;
    check("beat_count", 64'(beats), 64'(n));
    check("done_seen", 64'(dones), 64'(1));
    check("done_halt_low", 64'(halt_cpu), 64'(0));
    check("done_busy_low", 64'(busy), 64'(0));
    tick();
    check("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    int  hits;
    bit  found;

    for (int i = 0; i < 256; i++) mem[i] = exp_word(8'(i));
    rst = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    abort = 1'b0; out_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("reset_outputs",
          64'({halt_cpu, mem_rd_en, out_valid, busy, done, mem_addr, out_addr, out_data}), 64'(0));
    rst = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'(0));

    // T1: basic 4-word dump, start pulsed while busy is ignored
    kick(8'h00, 9'd4);
    check("t1_halt_after_start", 64'(halt_cpu), 64'(1));
    check("t1_busy_after_start", 64'(busy), 64'(1));
    check("t1_no_valid_e0", 64'(out_valid), 64'(0));
    tick();
    check("t1_no_valid_e1", 64'(out_valid), 64'(0));
    tick();
    check("t1_no_valid_e2", 64'(out_valid), 64'(0));
    check("t1_no_read_e2", 64'(mem_rd_en), 64'(0));
    start = 1'b1; base_addr = 8'h80; count = 9'd1;
    tick();
    start = 1'b0;
    check("t1_read_strobe", 64'(mem_rd_en), 64'(1));
    check("t1_read_addr", 64'(mem_addr), 64'(0));
    check("t1_no_valid_e3", 64'(out_valid), 64'(0));
    tick();
    check("t1_first_valid", 64'(out_valid), 64'(1));
    check("t1_first_data", 64'(out_data), 64'(32'h11111111));
    check("t1_first_addr", 64'(out_addr), 64'(0));
    drain(8'h00, 4, -1, 0);

    // T2: sink stalls for 5 cycles on the second beat
    kick(8'h00, 9'd4);
    drain(8'h00, 4, 1, 5);

    // T3: address wrap and whole-memory dump
    kick(8'hFE, 9'd4);
    drain(8'hFE, 4, -1, 0);
    kick(8'h00, 9'd256);
    drain(8'h00, 256, -1, 0);

    // T4: empty dump
    kick(8'h40, 9'd0);
    check("t4_done", 64'(done), 64'(1));
    check("t4_quiet", 64'({halt_cpu, out_valid, busy}), 64'(0));
    tick();
    check("t4_done_pulse", 64'(done), 64'(0));
    check("t4_still_quiet", 64'({halt_cpu, out_valid, busy}), 64'(0));

    // T5: abort while the second beat waits, with a handshake in the same cycle
    kick(8'h10, 9'd4);
    found = 0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      if (out_valid && out_addr == 8'h11) found = 1;
      else tick();
    end
    check("t5_reached_beat", 64'(found), 64'(1));
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_aborted", 64'({out_valid, halt_cpu, busy, done}), 64'(0));
    hits = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (done || out_valid || busy || halt_cpu) hits++;
    end
    check("t5_stays_idle", 64'(hits), 64'(0));

    // T6: asynchronous reset in the middle of a read, then a fresh dump
    kick(8'h20, 9'd4);
    found = 0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      if (mem_rd_en) found = 1;
      else tick();
    end
    check("t6_reached_read", 64'(found), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("t6_async_clear",
          64'({halt_cpu, mem_rd_en, out_valid, busy, done, mem_addr, out_addr, out_data}), 64'(0));
    tick();
    rst = 1'b1;
    tick();
    kick(8'h20, 9'd4);
    drain(8'h20, 4, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
